univ_reg_file: RTL and testbench

Parametrised bank of DEPTH universal registers, WIDTH bits each, for the tiny CPU datapath. It supersedes the single load/hold register with per-cycle operations on one addressed register: load, increment, decrement, shift, rotate and clear. It also provides two combinational read ports and registered carry/zero flags. It sits between the control unit (op/address) and the ALU operand muxes.

---
 rtl/univ_reg_pkg.sv | 11 +
 rtl/univ_alu.sv | 41 ++++
 rtl/univ_reg_file.sv | 71 +++++++
 tb/tb_univ_reg_file.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - op encoding shared by the register file and its ALU
package univ_reg_pkg;
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_ROL  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;
endpackage

// File: rtl/univ_alu.sv
// rtl/univ_alu.sv - combinational next-value and carry for one register op
module univ_alu
   import univ_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] res_o,
   output logic             c_o
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      res_o = cur_i;
      c_o   = 1'b0;
      case (op_i)
         OP_LOAD: res_o = wdata_i;
         OP_INC:  {c_o, res_o} = {1'b0, cur_i} + {1'b0, ONE};
         OP_DEC: begin
            res_o = cur_i - ONE;
            c_o   = (cur_i == '0);
         end
         OP_SHL: begin
            res_o = {cur_i[WIDTH-2:0], 1'b0};
            c_o   = cur_i[WIDTH-1];
         end
         OP_SHR: begin
            res_o = {1'b0, cur_i[WIDTH-1:1]};
            c_o   = cur_i[0];
         end
         OP_ROL: begin
            res_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
            c_o   = cur_i[WIDTH-1];
         end
         OP_CLR:  res_o = '0;
         default: res_o = cur_i;
      endcase
   end
endmodule

// File: rtl/univ_reg_file.sv
// rtl/univ_reg_file.sv - bank of universal registers with two read ports and carry/zero flags
module univ_reg_file
   import univ_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             carry,
   output logic             zero
);
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] cur_val, alu_res;
   logic             alu_c, w_hit, we;

   // Decode by comparing against each index so out-of-range addresses simply match nothing.
   always_comb begin
      cur_val = '0;
      w_hit   = 1'b0;
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (AW'(i) == waddr) begin
            cur_val = regs_q[i];
            w_hit   = 1'b1;
         end
         if (AW'(i) == raddr_a) rdata_a = regs_q[i];
         if (AW'(i) == raddr_b) rdata_b = regs_q[i];
      end
   end

   univ_alu #(.WIDTH(WIDTH)) u_alu (
      .op_i    (op),
      .cur_i   (cur_val),
      .wdata_i (wdata),
      .res_o   (alu_res),
      .c_o     (alu_c)
   );

   assign we      = w_hit && (op != OP_HOLD);
   assign carry_d = we ? alu_c : carry_q;
   assign zero_d  = we ? (alu_res == '0) : zero_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         carry_q <= carry_d;
         zero_q  <= zero_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (we && (AW'(i) == waddr)) regs_q[i] <= alu_res;
         end
      end
   end

   assign carry = carry_q;
   assign zero  = zero_q;
endmodule

// File: tb/tb_univ_reg_file.sv
// tb/tb_univ_reg_file.sv - scoreboard bench for univ_reg_file at DEPTH=4 and DEPTH=3
module tb_univ_reg_file;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] op;
   logic [1:0] waddr, raddr_a, raddr_b;
   logic [7:0] wdata;
   logic [7:0] rda4, rdb4, rda3, rdb3;
   logic       carry4, zero4, carry3, zero3;

   always #5 clk = ~clk;

   univ_reg_file #(.WIDTH(8), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .op(op), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda4), .rdata_b(rdb4),
      .carry(carry4), .zero(zero4)
   );

   univ_reg_file #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .op(op), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda3), .rdata_b(rdb3),
      .carry(carry3), .zero(zero3)
   );

   typedef struct {
      logic [7:0] a4, b4, a3, b3;
      logic       c4, z4, c3, z3;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   int m4[4];
   int m3[3];
   int c4, z4, c3, z3;

   // Reference behaviour in plain integer arithmetic on 8-bit values.
   function automatic void ref_op(input int o, input int v, input int wd, output int r, output int c);
      case (o)
         1: begin r = wd;               c = 0;              end
         2: begin r = (v + 1) % 256;    c = (v == 255);     end
         3: begin r = (v + 255) % 256;  c = (v == 0);       end
         4: begin r = (v * 2) % 256;    c = v / 128;        end
         5: begin r = v / 2;            c = v % 2;          end
         6: begin r = (v * 2) % 256 + v / 128; c = v / 128; end
         default: begin r = 0;          c = 0;              end
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m4[i] = 0;
      for (int i = 0; i < 3; i++) m3[i] = 0;
      c4 = 0; z4 = 1; c3 = 0; z3 = 1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Drive one cycle's inputs; the expectation describes what the outputs show before this op executes.
   task automatic step(input int o, input int wa, input int wd, input int ra, input int rb, input bit r);
      exp_t e;
      int   res, cc;
      @(posedge clk);
      #2;
      rst = r; op = o[2:0]; waddr = wa[1:0]; wdata = wd[7:0];
      raddr_a = ra[1:0]; raddr_b = rb[1:0];
      e.a4 = m4[ra][7:0];
      e.b4 = m4[rb][7:0];
      e.a3 = (ra < 3) ? m3[ra][7:0] : 8'h00;
      e.b3 = (rb < 3) ? m3[rb][7:0] : 8'h00;
      e.c4 = c4[0]; e.z4 = z4[0]; e.c3 = c3[0]; e.z3 = z3[0];
      exp_q.push_back(e);
      if (r) begin
         model_reset();
      end else if (o != 0) begin
         ref_op(o, m4[wa], wd, res, cc);
         m4[wa] = res; c4 = cc; z4 = (res == 0);
         if (wa < 3) begin
            ref_op(o, m3[wa], wd, res, cc);
            m3[wa] = res; c3 = cc; z3 = (res == 0);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("d4_rdata_a", rda4, e.a4);
         chk("d4_rdata_b", rdb4, e.b4);
         chk("d4_carry", {7'd0, carry4}, {7'd0, e.c4});
         chk("d4_zero", {7'd0, zero4}, {7'd0, e.z4});
         chk("d3_rdata_a", rda3, e.a3);
         chk("d3_rdata_b", rdb3, e.b3);
         chk("d3_carry", {7'd0, carry3}, {7'd0, e.c3});
         chk("d3_zero", {7'd0, zero3}, {7'd0, e.z3});
      end
   end

   initial begin
      int waited;
      rst = 1'b1; op = 3'd0; waddr = 2'd0; wdata = 8'd0; raddr_a = 2'd0; raddr_b = 2'd0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 2, 3, 0);
      step(1, 1, 'hAA, 0, 1, 1);
      step(0, 0, 0, 1, 2, 0);
      step(1, 1, 'hA5, 1, 2, 0);
      step(1, 2, 'h3C, 1, 2, 0);
      step(0, 0, 0, 1, 2, 0);
      step(0, 0, 0, 0, 3, 0);
      step(1, 0, 'hFF, 0, 0, 0);
      step(2, 0, 0, 0, 0, 0);
      step(3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 3, 'h81, 3, 3, 0);
      step(4, 3, 0, 3, 3, 0);
      step(5, 3, 0, 3, 3, 0);
      step(1, 3, 'h80, 3, 3, 0);
      step(6, 3, 0, 3, 3, 0);
      step(0, 0, 0, 3, 3, 0);
      step(7, 2, 0, 2, 2, 0);
      step(2, 2, 0, 2, 2, 0);
      for (int i = 0; i < 3; i++) step(0, i, 'h5A, i, 2, 0);
      step(7, 2, 0, 0, 1, 0);
      step(0, 0, 0, 2, 3, 0);
      step(1, 3, 'h55, 3, 0, 0);
      step(0, 0, 0, 3, 1, 0);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 39) == 0));
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, i, 3 - i, 0);
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
